// File: rtl/cpu_pkg.sv
// Shared types and defaults for the 16-bit CPU.
// Holds the fetch FSM state encoding and the instruction-word type.
package cpu_pkg;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 16;
  localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = 16'h0000;

  typedef logic [CPU_DATA_W-1:0] instr_t;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    VALID,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads the instruction BRAM and
// hands each fetched word to the decoder over a valid/ready handshake.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                DATA_W   = CPU_DATA_W,
  parameter int                BRAM_LAT = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = CPU_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_rd_en,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam logic [2:0] LAT_LAST = 3'(BRAM_LAT);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [2:0]        lat_cnt;

  // The strobe is held off during reset so a read is never issued from stale state.
  assign bram_rd_en = (state == ISSUE) && !halt && !reset;
  assign bram_addr  = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ISSUE;
      pc          <= RESET_PC;
      lat_cnt     <= '0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (jump_en) begin
      // A redirect abandons whatever is in flight; any pending handshake counts as taken.
      state       <= ISSUE;
      pc          <= jump_target;
      lat_cnt     <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        ISSUE: begin
          if (halt) begin
            state <= HALTED;
          end else begin
            state   <= WAIT;
            lat_cnt <= 3'd1;
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            instr_out   <= bram_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= VALID;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        VALID: begin
          if (instr_valid && instr_ready) begin
            pc          <= pc + ADDR_W'(1);
            instr_valid <= 1'b0;
            state       <= ISSUE;
          end
        end
        HALTED: begin
          if (!halt) begin
            state <= ISSUE;
          end
        end
        default: state <= ISSUE;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the 16-bit CPU.
- Owns the program-counter register and drives address and read enable to the instruction BRAM.
- Waits out the BRAM read latency, then presents the fetched word to the decoder/control FSM over a valid/ready handshake.
- Takes redirect requests (jumps/branches) from the execute stage, flushing any in-flight fetch.

Parameters:
- ADDR_W, 16, PC and BRAM address width.
- DATA_W, 16, instruction word width.
- BRAM_LAT, 1, BRAM read latency in cycles. Legal range 1..4.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- jump_en  input  1  redirect request from execute stage. Single-cycle pulse.
- jump_target  input  ADDR_W  absolute redirect address, sampled when jump_en=1.
- halt  input  1  stop issuing new fetches while high.
- bram_addr  output  ADDR_W  instruction BRAM read address.
- bram_rd_en  output  1  BRAM read strobe.
- bram_rdata  input  DATA_W  BRAM read data, valid BRAM_LAT cycles after the strobe.
- instr_out  output  DATA_W  fetched instruction.
- instr_pc  output  ADDR_W  address instr_out was fetched from.
- instr_valid  output  1  instr_out/instr_pc valid.
- instr_ready  input  1  consumer accepts the instruction this cycle.

Behaviour:
Clocking and reset:
- Single clock domain. All state updates on the rising clk edge.
- Reset is synchronous, active-high.
- Reset values: pc=RESET_PC, state=ISSUE, bram_rd_en=0, bram_addr=RESET_PC, instr_out=0, instr_pc=0, instr_valid=0, latency counter=0.
- Reset asserted in any state overrides everything, including jump_en, and discards any in-flight read.

States:
- ISSUE:
  - If halt=1: go to HALTED, rd_en=0.
  - Otherwise: bram_rd_en=1, bram_addr=pc (combinational from state and pc). Go to WAIT; counter=1.
- WAIT:
  - rd_en=0.
  - When counter==BRAM_LAT, capture bram_rdata into instr_out and pc into instr_pc, then go to VALID.
  - Otherwise increment the counter.
- VALID:
  - instr_valid=1. instr_out and instr_pc stay stable until the handshake.
  - On instr_valid && instr_ready: pc <= pc+1, instr_valid drops next cycle, go to ISSUE.
- HALTED:
  - rd_en=0, instr_valid=0.
  - When halt=0, go to ISSUE with pc unchanged.

Latency and throughput:
- With BRAM_LAT=1: ISSUE at cycle t, data captured at the end of t+1, instr_valid=1 at t+2.
- Best-case throughput is one instruction per BRAM_LAT+2 cycles.

Arithmetic:
- pc+1 is ADDR_W-bit modulo: 16'hFFFF wraps to 16'h0000, with no flag.

Redirect:
- jump_en=1 in any state except during reset: pc <= jump_target, state <= ISSUE, instr_valid <= 0, counter cleared.
- Any BRAM data in flight is discarded and never captured.
- jump_en in the same cycle as a completed handshake: the handshake counts as consumed and jump_target wins over pc+1.
- jump_en while halt=1: pc is loaded; the next ISSUE then goes to HALTED until halt=0.

Halt:
- halt is sampled only in ISSUE.
- A fetch already in WAIT or VALID completes normally.

No backpressure toward the BRAM:
- The BRAM is assumed always ready.
- instr_ready low simply holds VALID indefinitely.

Decomposition:
- cpu_pkg holds:
  - the fetch state enum (ISSUE, WAIT, VALID, HALTED);
  - ADDR_W/DATA_W defaults;
  - RESET_PC default;
  - the shared instruction-word typedef.
- No sub-module. The next-PC selection (jump_target vs pc+1) and the latency counter are small enough to stay inline.

Test Plan:
- Reset, BRAM preloaded mem[0]=16'hA001, mem[1]=16'hA002, instr_ready=1 → instr_valid at cycle 2 after reset release with instr_out=A001, instr_pc=0. Second word A002, instr_pc=1, arrives 3 cycles later.
- instr_ready held low 5 cycles while instr_valid=1 → instr_out/instr_pc stable, no bram_rd_en pulse. Raising instr_ready advances pc by exactly 1.
- jump_en with jump_target=16'h0040 during WAIT → in-flight word never appears. Next bram_addr=0x0040 and next instr_pc=0x0040.
- jump_en (target 0x0010) coincident with a VALID handshake at pc=5 → the word from pc 5 is consumed once, next fetch address is 0x0010, not 6.
- halt=1 before ISSUE at pc=3 → no rd_en while halted. Release halt → fetch resumes at pc=3. Separately, jump to 0xFFFF then accept → next address 0x0000.
- reset asserted mid-WAIT with BRAM_LAT=3 → instr_valid stays 0, next fetch at RESET_PC, stale data never captured.
